// File: rtl/moka_rv32_pkg.sv
// rtl/moka_rv32_pkg.sv - shared RV32 fetch constants and fetch state encoding
// Optional macro IF_MISALIGN_TRAP_EN adds the ERROR state encoding.
package moka_rv32_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned ILEN   = 32;
    localparam int unsigned PC_INC = 4;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_STALL = 2'd2;
`ifdef IF_MISALIGN_TRAP_EN
    localparam logic [1:0] ST_ERROR = 2'd3;
`endif

endpackage

// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - next-PC selection: hold, sequential increment or branch redirect
// Macro IF_MISALIGN_TRAP_EN: a misaligned target leaves the PC unchanged.
module pc_gen
    import moka_rv32_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = XLEN
) (
    input  logic [1:0]            i_state,
    input  logic                  i_acc,
    input  logic                  i_branch_taken,
    input  logic [DATA_WIDTH-1:0] i_branch_target,
    input  logic [DATA_WIDTH-1:0] i_pc,
    output logic [DATA_WIDTH-1:0] o_pc_next
);

    localparam logic [DATA_WIDTH-1:0] ALIGN_MASK = ~DATA_WIDTH'(3);

    logic w_active;

    assign w_active = (i_state == ST_FETCH) || (i_state == ST_STALL);

    // Redirect beats sequential advance; the increment wraps naturally at the top of the space.
    always_comb begin
        o_pc_next = i_pc;
        if (w_active) begin
            if (i_branch_taken) begin
`ifdef IF_MISALIGN_TRAP_EN
                if (i_branch_target[1:0] == 2'b00) begin
                    o_pc_next = i_branch_target;
                end
`else
                o_pc_next = i_branch_target & ALIGN_MASK;
`endif
            end else if (i_acc) begin
                o_pc_next = i_pc + DATA_WIDTH'(PC_INC);
            end
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - fetch stage: state machine, IF/ID capture register, imem interface
// Macro IF_MISALIGN_TRAP_EN: adds misalign_err output and a reset-only ERROR state.
module instruction_fetch
    import moka_rv32_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH = XLEN,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = DATA_WIDTH'(RESET_PC_DEFAULT)
) (
    input  logic                  clk,
    input  logic                  rstn,
    output logic                  imem_en,
    output logic [DATA_WIDTH-1:0] imem_addr,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    input  logic                  branch_taken,
    input  logic [DATA_WIDTH-1:0] branch_target,
    output logic                  id_valid,
    input  logic                  id_ready,
    output logic [DATA_WIDTH-1:0] id_instr,
    output logic [DATA_WIDTH-1:0] id_pc
`ifdef IF_MISALIGN_TRAP_EN
    ,
    output logic                  misalign_err
`endif
);

    logic [1:0]            r_state;
    logic [1:0]            w_state_next;
    logic [DATA_WIDTH-1:0] r_pc;
    logic [DATA_WIDTH-1:0] w_pc_next;
    logic [DATA_WIDTH-1:0] r_id_instr;
    logic [DATA_WIDTH-1:0] r_id_pc;
    logic                  r_id_valid;
    logic                  w_acc;
    logic                  w_active;
    logic                  w_redirect;
    logic                  w_capture;

    assign w_acc      = !r_id_valid || id_ready;
    assign w_active   = (r_state == ST_FETCH) || (r_state == ST_STALL);
    assign w_redirect = w_active && branch_taken;
    assign w_capture  = w_active && !branch_taken && w_acc;

    assign imem_en   = w_active;
    assign imem_addr = {2'b00, r_pc[DATA_WIDTH-1:2]};
    assign id_valid  = r_id_valid;
    assign id_instr  = r_id_instr;
    assign id_pc     = r_id_pc;

`ifdef IF_MISALIGN_TRAP_EN
    logic w_misalign;
    logic r_misalign_err;

    assign w_misalign   = branch_taken && (branch_target[1:0] != 2'b00);
    assign misalign_err = r_misalign_err;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_misalign_err <= 1'b0;
        end else if (w_redirect && w_misalign) begin
            r_misalign_err <= 1'b1;
        end
    end
`endif

    pc_gen #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_pc_gen (
        .i_state         (r_state),
        .i_acc           (w_acc),
        .i_branch_taken  (branch_taken),
        .i_branch_target (branch_target),
        .i_pc            (r_pc),
        .o_pc_next       (w_pc_next)
    );

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: w_state_next = ST_FETCH;
            ST_FETCH, ST_STALL: begin
                if (branch_taken || w_acc) begin
                    w_state_next = ST_FETCH;
                end else begin
                    w_state_next = ST_STALL;
                end
`ifdef IF_MISALIGN_TRAP_EN
                if (w_misalign) begin
                    w_state_next = ST_ERROR;
                end
`endif
            end
`ifdef IF_MISALIGN_TRAP_EN
            ST_ERROR: w_state_next = ST_ERROR;
`endif
            default: w_state_next = ST_IDLE;
        endcase
    end

    // A redirect only flushes the valid bit; the stale instr/pc are never presented as valid.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= ST_IDLE;
            r_pc       <= RESET_PC;
            r_id_valid <= 1'b0;
            r_id_instr <= '0;
            r_id_pc    <= '0;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            if (w_redirect) begin
                r_id_valid <= 1'b0;
            end else if (w_capture) begin
                r_id_valid <= 1'b1;
                r_id_instr <= imem_rdata;
                r_id_pc    <= r_pc;
            end
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - self-checking bench for instruction_fetch
// Macro IF_MISALIGN_TRAP_EN selects the trap-enabled expectations.
module tb_instruction_fetch;

    typedef struct {
        logic        rdy;
        logic        br;
        logic [31:0] tgt;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_addr;
    } vec_t;

    logic        clk = 1'b0;
    logic        rstn;
    logic        imem_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
`ifdef IF_MISALIGN_TRAP_EN
    logic        misalign_err;
    logic        misalign_err2;
`endif

    logic        rstn2;
    logic        imem_en2;
    logic [31:0] imem_addr2;
    logic [31:0] imem_rdata2;
    logic        id_valid2;
    logic [31:0] id_instr2;
    logic [31:0] id_pc2;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    assign imem_rdata  = mem_word(imem_addr);
    assign imem_rdata2 = mem_word(imem_addr2);

    instruction_fetch u_dut (
        .clk           (clk),
        .rstn          (rstn),
        .imem_en       (imem_en),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .id_valid      (id_valid),
        .id_ready      (id_ready),
        .id_instr      (id_instr),
        .id_pc         (id_pc)
`ifdef IF_MISALIGN_TRAP_EN
        ,
        .misalign_err  (misalign_err)
`endif
    );

    instruction_fetch #(
        .RESET_PC (32'hFFFF_FFF8)
    ) u_dut_wrap (
        .clk           (clk),
        .rstn          (rstn2),
        .imem_en       (imem_en2),
        .imem_addr     (imem_addr2),
        .imem_rdata    (imem_rdata2),
        .branch_taken  (1'b0),
        .branch_target (32'h0),
        .id_valid      (id_valid2),
        .id_ready      (1'b1),
        .id_instr      (id_instr2),
        .id_pc         (id_pc2)
`ifdef IF_MISALIGN_TRAP_EN
        ,
        .misalign_err  (misalign_err2)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn          = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 32'h0;
        id_ready      = 1'b1;
        cyc();
        cyc();
        rstn = 1'b1;
    endtask

    vec_t tbl[12];

    logic        m_run;
    logic        m_valid;
    logic [31:0] m_pc;
    logic [31:0] m_idpc;
    logic [31:0] m_instr;
    logic [31:0] t;

    initial begin
        tbl[0]  = '{1'b1, 1'b1, 32'h80,        1'b0, 32'h0,        32'h0};
        tbl[1]  = '{1'b1, 1'b0, 32'h0,         1'b1, 32'h0,        32'h1};
        tbl[2]  = '{1'b1, 1'b0, 32'h0,         1'b1, 32'h4,        32'h2};
        tbl[3]  = '{1'b1, 1'b0, 32'h0,         1'b1, 32'h8,        32'h3};
        tbl[4]  = '{1'b1, 1'b0, 32'h0,         1'b1, 32'hC,        32'h4};
        tbl[5]  = '{1'b0, 1'b0, 32'h0,         1'b1, 32'hC,        32'h4};
        tbl[6]  = '{1'b0, 1'b1, 32'h40,        1'b0, 32'h0,        32'h10};
        tbl[7]  = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h40,       32'h11};
        tbl[8]  = '{1'b1, 1'b0, 32'h0,         1'b1, 32'h44,       32'h12};
        tbl[9]  = '{1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0,        32'h3FFF_FFFF};
        tbl[10] = '{1'b1, 1'b0, 32'h0,         1'b1, 32'hFFFF_FFFC, 32'h0};
        tbl[11] = '{1'b1, 1'b0, 32'h0,         1'b1, 32'h0,        32'h1};

        rstn2 = 1'b0;
        rstn  = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 32'h0;
        id_ready      = 1'b1;
        #2;
        chk("rst_valid", {31'b0, id_valid}, 32'h0);
        chk("rst_en", {31'b0, imem_en}, 32'h0);
        chk("rst_pc", id_pc, 32'h0);
        chk("rst_instr", id_instr, 32'h0);
        chk("rst_addr", imem_addr, 32'h0);
`ifdef IF_MISALIGN_TRAP_EN
        chk("rst_merr", {31'b0, misalign_err}, 32'h0);
`endif

        // table: startup sequence, stall, redirects, wrap through the address top
        do_reset();
        chk("idle_en", {31'b0, imem_en}, 32'h0);
        for (int i = 0; i < 12; i++) begin
            id_ready      = tbl[i].rdy;
            branch_taken  = tbl[i].br;
            branch_target = tbl[i].tgt;
            cyc();
            chk($sformatf("tbl%0d_valid", i), {31'b0, id_valid}, {31'b0, tbl[i].e_valid});
            chk($sformatf("tbl%0d_addr", i), imem_addr, tbl[i].e_addr);
            chk($sformatf("tbl%0d_en", i), {31'b0, imem_en}, 32'h1);
            if (tbl[i].e_valid) begin
                chk($sformatf("tbl%0d_pc", i), id_pc, tbl[i].e_pc);
                chk($sformatf("tbl%0d_instr", i), id_instr, mem_word(tbl[i].e_pc >> 2));
            end
        end
        branch_taken = 1'b0;

        // stall while id_pc=4, then branch while stalled
        do_reset();
        cyc(); cyc(); cyc();
        chk("pre_stall_pc", id_pc, 32'h4);
        id_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("stall_pc", id_pc, 32'h4);
            chk("stall_instr", id_instr, mem_word(32'h1));
            chk("stall_addr", imem_addr, 32'h2);
            chk("stall_valid", {31'b0, id_valid}, 32'h1);
        end
        id_ready = 1'b1;
        cyc();
        chk("unstall_pc", id_pc, 32'h8);
        chk("unstall_instr", id_instr, mem_word(32'h2));
        id_ready = 1'b0;
        cyc();
        chk("stall2_pc", id_pc, 32'h8);
        branch_taken  = 1'b1;
        branch_target = 32'h10;
        cyc();
        branch_taken = 1'b0;
        chk("br_stall_valid", {31'b0, id_valid}, 32'h0);
        chk("br_stall_addr", imem_addr, 32'h4);
        cyc();
        chk("br_tgt_valid", {31'b0, id_valid}, 32'h1);
        chk("br_tgt_pc", id_pc, 32'h10);
        chk("br_tgt_instr", id_instr, mem_word(32'h4));

        // misaligned branch target
        id_ready      = 1'b1;
        branch_taken  = 1'b1;
        branch_target = 32'h6;
        cyc();
        branch_taken = 1'b0;
`ifdef IF_MISALIGN_TRAP_EN
        for (int i = 0; i < 3; i++) begin
            chk("mis_err", {31'b0, misalign_err}, 32'h1);
            chk("mis_valid", {31'b0, id_valid}, 32'h0);
            chk("mis_en", {31'b0, imem_en}, 32'h0);
            cyc();
        end
        rstn = 1'b0;
        #1;
        chk("mis_err_clr", {31'b0, misalign_err}, 32'h0);
        rstn = 1'b1;
`else
        chk("mis_valid", {31'b0, id_valid}, 32'h0);
        chk("mis_addr", imem_addr, 32'h1);
        cyc();
        chk("mis_pc", id_pc, 32'h4);
        chk("mis_valid2", {31'b0, id_valid}, 32'h1);
`endif

        // asynchronous reset mid-cycle
        do_reset();
        cyc(); cyc(); cyc(); cyc();
        chk("pre_async_valid", {31'b0, id_valid}, 32'h1);
        #3;
        rstn = 1'b0;
        #1;
        chk("async_valid", {31'b0, id_valid}, 32'h0);
        chk("async_pc", id_pc, 32'h0);
        chk("async_instr", id_instr, 32'h0);
        chk("async_en", {31'b0, imem_en}, 32'h0);
        chk("async_addr", imem_addr, 32'h0);
        #2;
        rstn = 1'b1;
        #1;
        chk("rel_idle_en", {31'b0, imem_en}, 32'h0);
        cyc();
        chk("rel_fetch_en", {31'b0, imem_en}, 32'h1);
        chk("rel_fetch_valid", {31'b0, id_valid}, 32'h0);
        cyc();
        chk("rel_first_pc", id_pc, 32'h0);
        chk("rel_first_valid", {31'b0, id_valid}, 32'h1);

        // wrap instance with RESET_PC near the top
        rstn2 = 1'b1;
        cyc();
        for (int i = 0; i < 3; i++) begin
            t = 32'hFFFF_FFF8 + 32'(i * 4);
            cyc();
            chk("wrap_valid", {31'b0, id_valid2}, 32'h1);
            chk("wrap_pc", id_pc2, t);
            chk("wrap_instr", id_instr2, mem_word(t >> 2));
        end

        // randomized run against a transaction-level model
        do_reset();
        m_run   = 1'b0;
        m_valid = 1'b0;
        m_pc    = 32'h0;
        m_idpc  = 32'h0;
        m_instr = 32'h0;
        for (int i = 0; i < 400; i++) begin
            id_ready     = ($urandom % 4) != 0;
            branch_taken = ($urandom % 8) == 0;
            t = (($urandom % 4) == 0) ? (32'hFFFF_FFF0 + ($urandom % 16)) : $urandom;
`ifdef IF_MISALIGN_TRAP_EN
            t = t & ~32'd3;
`endif
            branch_target = t;
            cyc();
            if (!m_run) begin
                m_run = 1'b1;
            end else if (branch_taken) begin
                m_pc    = branch_target & ~32'd3;
                m_valid = 1'b0;
            end else if (!m_valid || id_ready) begin
                m_valid = 1'b1;
                m_idpc  = m_pc;
                m_instr = mem_word(m_pc >> 2);
                m_pc    = m_pc + 32'd4;
            end
            chk("rnd_en", {31'b0, imem_en}, {31'b0, m_run});
            chk("rnd_valid", {31'b0, id_valid}, {31'b0, m_valid});
            chk("rnd_addr", imem_addr, {2'b00, m_pc[31:2]});
            if (m_valid) begin
                chk("rnd_pc", id_pc, m_idpc);
                chk("rnd_instr", id_instr, m_instr);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
